button_debouncer_array: RTL and testbench
=========================================

// Module: button_debouncer_array
// PURPOSE
//  Parametrised N-channel button conditioner for the board push-buttons that feed game control.
//  Per channel: synchroniser, symmetric press/release debounce, one-cycle press/release strobes,
//  and an optional hold-to-repeat strobe for continuous player movement.
//  Sits between the board pins and the player/menu control FSMs; replaces per-button debounce instances.
// PARAMETERS
//  N_BTN          5       number of independent button channels (>=1)
//  SYNC_STAGES    2       synchroniser flop depth per channel (>=2)
//  DB_CYCLES      200000  consecutive stable cycles required to accept a level change (>=1; 2 ms @100 MHz)
//  REPEAT_DELAY   50000000 cycles from press strobe to first repeat strobe; 0 = repeat disabled
//  REPEAT_PERIOD  10000000 cycles between subsequent repeat strobes (>=1)
// PORTS
//  clk        in   1      system clock
//  reset      in   1      synchronous, active-high reset
//  btn_raw    in   N_BTN  asynchronous raw button pins, 1 = pressed
//  btn_level  out  N_BTN  debounced level, 1 = held
//  btn_press  out  N_BTN  one-cycle strobe on accepted 0->1
//  btn_rel    out  N_BTN  one-cycle strobe on accepted 1->0
//  btn_rpt    out  N_BTN  one-cycle auto-repeat strobe while held
//  any_press  out  1      OR of btn_press (registered with it, same cycle)
// BEHAVIOUR
//  - Reset (synchronous, active-high): synchroniser flops, counters, all outputs -> 0; state RELEASED.
//  - Sync: btn_raw[i] passes SYNC_STAGES flops -> s[i]. Channels fully independent.
//  - Debounce counter db_cnt, width $clog2(DB_CYCLES+1) (min 1):
//      s==level -> db_cnt<=0; s!=level & db_cnt<DB_CYCLES-1 -> db_cnt+1;
//      s!=level & db_cnt==DB_CYCLES-1 -> level<=s, db_cnt<=0, press/rel strobe asserted next cycle with level.
//  - Latency: clean edge on btn_raw at edge 0 -> btn_level/strobe visible after edge SYNC_STAGES+DB_CYCLES.
//  - Any bounce (s returning to level) before the count completes restarts the count from 0; no strobe.
//  - Per-channel states: RELEASED (level 0) -> PRESSING (counting) -> HELD (level 1) -> RELEASING -> RELEASED;
//    PRESSING/RELEASING fall back on bounce. Strobes are exactly one cycle wide; never both in one cycle.
//  - Repeat (REPEAT_DELAY>0): rpt_cnt clears on press strobe; in HELD/RELEASING counts up;
//    first btn_rpt REPEAT_DELAY cycles after btn_press, then every REPEAT_PERIOD cycles while level=1.
//    Short release glitches (< DB_CYCLES) do not disturb rpt_cnt. Release strobe clears rpt_cnt, no rpt that cycle.
//    rpt_cnt saturating logic: width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1); no wrap.
//  - REPEAT_DELAY==0: btn_rpt tied 0, repeat counter not generated.
//  - Simultaneous channel events: each channel strobes independently; any_press = |btn_press.
//  - Reset mid-debounce or mid-hold: all progress discarded; a button held through reset
//    re-qualifies and yields a fresh btn_press SYNC_STAGES+DB_CYCLES cycles after reset release.
//  - All outputs registered; no combinational path btn_raw -> outputs.
// STRUCTURE
//  - Shared include (input_defs.vh): channel index constants (BTN_UP/DOWN/LEFT/RIGHT/FIRE = 0..4),
//    default DB_CYCLES / REPEAT_* for 100 MHz, state encodings RELEASED/PRESSING/HELD/RELEASING.
//  - Sub-module debounce_channel (one channel: sync, db_cnt, state, rpt_cnt, 4 registered outputs);
//    top instantiates N_BTN copies via generate loop and ORs btn_press.
// TESTING  (bench params: N_BTN=2, SYNC_STAGES=2, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1 Clean press ch0 at cycle 0, hold -> btn_level[0]=1 and btn_press[0]=1 for one cycle at cycle 6; ch1 quiet.
//  2 Bounce ch0: high 3 cycles, low 1, high steady -> no strobe during bounce; single press 6 cycles after final rise.
//  3 Hold ch0 40 cycles after press -> btn_rpt[0] at press+10, +13, +16, ...; release -> btn_rel[0] one cycle, rpt stops.
//  4 Both channels pressed same cycle -> btn_press=2'b11 in one cycle, any_press=1 that cycle only.
//  5 Glitch low for 2 cycles while held -> btn_level stays 1, no rel strobe, repeat cadence unchanged.
//  6 reset asserted mid-hold for 3 cycles, button kept high -> all outputs 0 during reset; new btn_press 6 cycles after release.

Source files
------------

// File: rtl/button_debouncer_array_pkg.sv
// Shared definitions for the push-button conditioner: channel indices,
// 100 MHz timing defaults, per-channel state encoding and width helpers.
package button_debouncer_array_pkg;

  // Board channel assignment for the game-control buttons.
  typedef enum int {
    BTN_UP    = 0,
    BTN_DOWN  = 1,
    BTN_LEFT  = 2,
    BTN_RIGHT = 3,
    BTN_FIRE  = 4
  } btn_idx_e;

  // Defaults for a 100 MHz clock: 2 ms debounce, 0.5 s first repeat, 0.1 s cadence.
  localparam int DEF_DB_CYCLES     = 200000;
  localparam int DEF_REPEAT_DELAY  = 50000000;
  localparam int DEF_REPEAT_PERIOD = 10000000;

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_PRESSING  = 2'd1,
    ST_HELD      = 2'd2,
    ST_RELEASING = 2'd3
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold v-1, never below one bit.
  function automatic int width_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/button_debouncer_array_channel.sv
// One button channel: synchroniser, symmetric debounce FSM, registered
// level/press/release strobes and an optional hold-to-repeat strobe.
module button_debouncer_array_channel
  import button_debouncer_array_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic rpt_o,
  output logic press_d_o
);

  localparam int DB_W = width_min1(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  btn_state_e             state_q, state_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_cur;
  logic                   db_done;
  logic                   level_q, press_q, rel_q;
  logic                   press_d, rel_d;

  // Synchroniser chain for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
  end

  assign s         = sync_q[SYNC_STAGES-1];
  assign level_cur = (state_q == ST_HELD) || (state_q == ST_RELEASING);
  assign db_done   = (db_cnt_q == DB_LAST);

  // Debounce state and stable-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RELEASED;
      db_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Next state: count while the synchronised input disagrees with the level,
  // fall back (count reset) on any bounce, accept on the last count.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = '0;
    case (state_q)
      ST_RELEASED, ST_PRESSING: begin
        if (!s)           state_d = ST_RELEASED;
        else if (db_done) state_d = ST_HELD;
        else begin
          state_d  = ST_PRESSING;
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      ST_HELD, ST_RELEASING: begin
        if (s)            state_d = ST_HELD;
        else if (db_done) state_d = ST_RELEASED;
        else begin
          state_d  = ST_RELEASING;
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RELEASED;
    endcase
  end

  // Strobes come from comparing the accepted level with its registered copy,
  // so press and release can never coincide and each lasts one cycle.
  assign press_d   = level_cur & ~level_q;
  assign rel_d     = ~level_cur & level_q;
  assign press_d_o = press_d;

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      level_q <= level_cur;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;

  if (REPEAT_DELAY > 0) begin : g_rpt
    localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RPT_W   = width_min1(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic             rpt_fire;
    logic             rpt_q;

    // Fire on the delay for the first strobe, then on the period; the counter
    // restarts at 1 after each strobe and saturates rather than wrapping.
    always_comb begin
      rpt_cnt_d   = rpt_cnt_q;
      rpt_phase_d = rpt_phase_q;
      rpt_fire    = level_cur &&
                    (rpt_phase_q ? (rpt_cnt_q == RPT_W'(REPEAT_PERIOD))
                                 : (rpt_cnt_q == RPT_W'(REPEAT_DELAY)));
      if (!level_cur) begin
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt_d   = RPT_W'(1);
        rpt_phase_d = 1'b1;
      end else if (rpt_cnt_q != RPT_W'(RPT_MAX)) begin
        rpt_cnt_d   = rpt_cnt_q + 1'b1;
      end
    end

    // Repeat counter, phase and registered strobe.
    always_ff @(posedge clk) begin
      if (reset) begin
        rpt_cnt_q   <= '0;
        rpt_phase_q <= 1'b0;
        rpt_q       <= 1'b0;
      end else begin
        rpt_cnt_q   <= rpt_cnt_d;
        rpt_phase_q <= rpt_phase_d;
        rpt_q       <= rpt_fire;
      end
    end

    assign rpt_o = rpt_q;
  end else begin : g_no_rpt
    assign rpt_o = 1'b0;
  end

endmodule

// File: rtl/button_debouncer_array.sv
// N independent debounced button channels plus a registered any-press flag.
module button_debouncer_array
  import button_debouncer_array_pkg::*;
#(
  parameter int N_BTN         = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_rel,
  output logic [N_BTN-1:0] btn_rpt,
  output logic             any_press
);

  logic [N_BTN-1:0] press_d;
  logic             any_press_q;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    button_debouncer_array_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn_raw_i(btn_raw[gi]),
      .level_o  (btn_level[gi]),
      .press_o  (btn_press[gi]),
      .rel_o    (btn_rel[gi]),
      .rpt_o    (btn_rpt[gi]),
      .press_d_o(press_d[gi])
    );
  end

  // Registered from the same next-press terms so it aligns with btn_press.
  always_ff @(posedge clk) begin
    if (reset) any_press_q <= 1'b0;
    else       any_press_q <= |press_d;
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_button_debouncer_array.sv
// Directed bench for the button conditioner with short timing parameters.
module tb_button_debouncer_array;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level, btn_press, btn_rel, btn_rpt;
  logic       any_press;

  int checks = 0;
  int errors = 0;

  button_debouncer_array #(
    .N_BTN(2), .SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_rel(btn_rel),
    .btn_rpt(btn_rpt), .any_press(any_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string tag, input int c, input logic [1:0] el,
                             input logic [1:0] ep, input logic [1:0] er,
                             input logic [1:0] erp, input logic ea);
    check($sformatf("%s c%0d level", tag, c), {6'b0, btn_level}, {6'b0, el});
    check($sformatf("%s c%0d press", tag, c), {6'b0, btn_press}, {6'b0, ep});
    check($sformatf("%s c%0d rel", tag, c),   {6'b0, btn_rel},   {6'b0, er});
    check($sformatf("%s c%0d rpt", tag, c),   {6'b0, btn_rpt},   {6'b0, erp});
    check($sformatf("%s c%0d any", tag, c),   {7'b0, any_press}, {7'b0, ea});
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    btn_raw = 2'b00;
    repeat (3) tick();
    check_cycle("reset", 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    reset = 1'b0;
  endtask

  // Repeat strobe expected at press(6)+10 then every 3 cycles, up to a last cycle.
  function automatic logic rpt_at(input int c, input int last);
    return (c >= 16) && (c <= last) && (((c - 16) % 3) == 0);
  endfunction

  initial begin
    // 1: clean press on ch0, ch1 quiet.
    do_reset();
    btn_raw = 2'b01;
    for (int c = 0; c <= 9; c++) begin
      tick();
      check_cycle("clean", c, {1'b0, c >= 6}, {1'b0, c == 6}, 2'b00, 2'b00, c == 6);
    end
    $display("scenario clean_press done, checks=%0d errors=%0d", checks, errors);

    // 2: bounce high 3, low 1, then steady high -> single press 6 after final rise (c=4).
    do_reset();
    btn_raw = 2'b01;
    for (int c = 0; c <= 13; c++) begin
      tick();
      check_cycle("bounce", c, {1'b0, c >= 10}, {1'b0, c == 10}, 2'b00, 2'b00, c == 10);
      if (c == 2) btn_raw = 2'b00;
      if (c == 3) btn_raw = 2'b01;
    end
    $display("scenario bounce done, checks=%0d errors=%0d", checks, errors);

    // 3: hold 40 cycles past press, then release (raw low from edge 47 -> rel at 53).
    do_reset();
    btn_raw = 2'b01;
    for (int c = 0; c <= 58; c++) begin
      tick();
      check_cycle("hold", c, {1'b0, (c >= 6) && (c <= 52)}, {1'b0, c == 6},
                  {1'b0, c == 53}, {1'b0, rpt_at(c, 52)}, c == 6);
      if (c == 46) btn_raw = 2'b00;
    end
    $display("scenario hold_repeat_release done, checks=%0d errors=%0d", checks, errors);

    // 4: both channels pressed in the same cycle.
    do_reset();
    btn_raw = 2'b11;
    for (int c = 0; c <= 8; c++) begin
      tick();
      check_cycle("both", c, (c >= 6) ? 2'b11 : 2'b00, (c == 6) ? 2'b11 : 2'b00,
                  2'b00, 2'b00, c == 6);
    end
    $display("scenario simultaneous done, checks=%0d errors=%0d", checks, errors);

    // 5: 2-cycle low glitch while held leaves level and repeat cadence intact.
    do_reset();
    btn_raw = 2'b01;
    for (int c = 0; c <= 35; c++) begin
      tick();
      check_cycle("glitch", c, {1'b0, c >= 6}, {1'b0, c == 6}, 2'b00,
                  {1'b0, rpt_at(c, 1000)}, c == 6);
      if (c == 20) btn_raw = 2'b00;
      if (c == 22) btn_raw = 2'b01;
    end
    $display("scenario glitch done, checks=%0d errors=%0d", checks, errors);

    // 6: reset for 3 cycles mid-hold with button kept high -> fresh press at 24+6.
    do_reset();
    btn_raw = 2'b01;
    for (int c = 0; c <= 32; c++) begin
      tick();
      if (c <= 20)
        check_cycle("rst_hold", c, {1'b0, c >= 6}, {1'b0, c == 6}, 2'b00,
                    {1'b0, rpt_at(c, 1000)}, c == 6);
      else if (c <= 23)
        check_cycle("rst_hold", c, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      else
        check_cycle("rst_hold", c, {1'b0, c >= 30}, {1'b0, c == 30}, 2'b00, 2'b00, c == 30);
      if (c == 20) reset = 1'b1;
      if (c == 23) reset = 1'b0;
    end
    $display("scenario reset_mid_hold done, checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
